// File: rtl/pc_stack_unit_pkg.sv
// Shared types for the program-counter unit: op encoding for the decode interface.
package pc_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_SEQ  = 3'd0,
    OP_JMP  = 3'd1,
    OP_BRR  = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4
  } pc_op_t;

endpackage

// File: rtl/pc_stack_unit_ra_stack.sv
// Return-address LIFO: push is ignored when full, pop is ignored when empty.
module ra_stack #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [IDX_W-1:0] wr_idx, top_idx;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_idx  = IDX_W'(count_q);
  assign top_idx = IDX_W'(count_q - CNT_W'(1));
  assign dout    = mem_q[top_idx];
  assign count   = count_q;

  // Push takes precedence; the owner never requests both in one cycle.
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (push && !full) begin
      mem_d[wr_idx] = din;
      count_d       = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Entries carry no reset; only the occupancy count defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with stall, jump, relative branch and CALL/RET return stack.
// Optional macro PC_WRAP_FLAG_EN adds the registered 'wrapped' increment-carry pulse.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int unsigned          PC_W        = 8,
  parameter int unsigned          STEP        = 1,
  parameter logic [PC_W-1:0]      RESET_PC    = '0,
  parameter int unsigned          STACK_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en,
  input  logic [OP_W-1:0]                 op,
  input  logic [PC_W-1:0]                 target,
  input  logic [PC_W-1:0]                 offset,
  output logic [PC_W-1:0]                 pc,
  output logic [$clog2(STACK_DEPTH):0]    sp,
`ifdef PC_WRAP_FLAG_EN
  output logic                            wrapped,
`endif
  output logic                            stack_empty,
  output logic                            stack_full,
  output logic                            ovf_err,
  output logic                            unf_err
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PC_W-1:0] pc_inc;
  logic            inc_carry;
  logic            push, pop;
  logic [PC_W-1:0] stk_dout;
  logic            stk_full, stk_empty;

`ifdef PC_WRAP_FLAG_EN
  logic [PC_W:0] inc_sum;
  logic          wrapped_q, wrapped_d;

  assign inc_sum   = {1'b0, pc_q} + (PC_W+1)'(STEP);
  assign pc_inc    = inc_sum[PC_W-1:0];
  assign inc_carry = inc_sum[PC_W];
  assign wrapped   = wrapped_q;
`else
  assign pc_inc    = pc_q + PC_W'(STEP);
  assign inc_carry = 1'b0;
`endif

  ra_stack #(
    .W     (PC_W),
    .DEPTH (STACK_DEPTH)
  ) u_ra_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .count (sp),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Next-PC select; increment is the fallback for SEQ, unknown ops and failed CALL/RET.
  always_comb begin
    pc_d      = pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
`ifdef PC_WRAP_FLAG_EN
    wrapped_d = 1'b0;
`endif
    if (en && rst_n) begin
      pc_d = pc_inc;
`ifdef PC_WRAP_FLAG_EN
      wrapped_d = inc_carry;
`endif
      case (op)
        OP_JMP: begin
          pc_d = target;
`ifdef PC_WRAP_FLAG_EN
          wrapped_d = 1'b0;
`endif
        end
        OP_BRR: begin
          pc_d = pc_q + offset;
`ifdef PC_WRAP_FLAG_EN
          wrapped_d = 1'b0;
`endif
        end
        OP_CALL: begin
          if (!stk_full) begin
            push = 1'b1;
            pc_d = target;
`ifdef PC_WRAP_FLAG_EN
            wrapped_d = 1'b0;
`endif
          end else begin
            ovf_d = 1'b1;
          end
        end
        OP_RET: begin
          if (!stk_empty) begin
            pop  = 1'b1;
            pc_d = stk_dout;
`ifdef PC_WRAP_FLAG_EN
            wrapped_d = 1'b0;
`endif
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
`ifdef PC_WRAP_FLAG_EN
      wrapped_q <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
`ifdef PC_WRAP_FLAG_EN
      wrapped_q <= wrapped_d;
`endif
    end
  end

  assign pc          = pc_q;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;
  assign stack_empty = stk_empty;
  assign stack_full  = stk_full;

`ifndef PC_WRAP_FLAG_EN
  logic unused_ok;
  assign unused_ok = inc_carry;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed table-driven bench for pc_stack_unit, plus an alternate STEP/RESET_PC instance.
module tb_pc_stack_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration instance
  logic       rst_n, en;
  logic [2:0] op;
  logic [7:0] target, offset, pc;
  logic [2:0] sp;
  logic       stack_empty, stack_full, ovf_err, unf_err;
`ifdef PC_WRAP_FLAG_EN
  logic       wrapped;
`endif

  pc_stack_unit #(.PC_W(8), .STEP(1), .RESET_PC(8'd0), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .target(target), .offset(offset),
    .pc(pc), .sp(sp),
`ifdef PC_WRAP_FLAG_EN
    .wrapped(wrapped),
`endif
    .stack_empty(stack_empty), .stack_full(stack_full),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // Alternate configuration: STEP=4, RESET_PC=16
  logic       rst2_n, en2;
  logic [2:0] op2;
  logic [7:0] target2, offset2, pc2;
  logic [2:0] sp2;
  logic       empty2, full2, ovf2, unf2;
`ifdef PC_WRAP_FLAG_EN
  logic       wrapped2;
`endif

  pc_stack_unit #(.PC_W(8), .STEP(4), .RESET_PC(8'd16), .STACK_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .op(op2), .target(target2), .offset(offset2),
    .pc(pc2), .sp(sp2),
`ifdef PC_WRAP_FLAG_EN
    .wrapped(wrapped2),
`endif
    .stack_empty(empty2), .stack_full(full2),
    .ovf_err(ovf2), .unf_err(unf2)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic [7:0] exp_pc;
    logic [2:0] exp_sp;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
    logic       exp_unf;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] o,
                              input logic [7:0] t, input logic [7:0] off,
                              input logic [7:0] p, input logic [2:0] s,
                              input logic ov, input logic un, input logic wr);
    vec_t v;
    v.rst_n = r; v.en = e; v.op = o; v.target = t; v.offset = off;
    v.exp_pc = p; v.exp_sp = s;
    v.exp_empty = (s == 3'd0); v.exp_full = (s == 3'd4);
    v.exp_ovf = ov; v.exp_unf = un; v.exp_wrap = wr;
    return v;
  endfunction

  task automatic check_dut2(input string name, input logic [7:0] e_pc, input logic [2:0] e_sp,
                            input logic e_unf);
    checks++;
    if (pc2 !== e_pc || sp2 !== e_sp || unf2 !== e_unf || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL %s: got pc=%0d sp=%0d unf=%b ovf=%b, expected pc=%0d sp=%0d unf=%b ovf=0",
               name, pc2, sp2, unf2, ovf2, e_pc, e_sp, e_unf);
    end
  endtask

  task automatic step2(input logic r, input logic [2:0] o, input logic [7:0] t);
    rst2_n = r; en2 = 1'b1; op2 = o; target2 = t; offset2 = 8'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; op = 3'd0; target = '0; offset = '0;
    rst2_n = 1'b0; en2 = 1'b1; op2 = 3'd0; target2 = '0; offset2 = '0;

    //                  rst en op       tgt   off    pc   sp ovf unf wrap
    vecs.push_back(mk(0, 1, OP_SEQ,  0,    0,     0,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, OP_SEQ,  0,    0,     0,   0, 0, 0, 0));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mk(1, 1, OP_SEQ, 0, 0, 8'(i), 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, OP_JMP, 77, 0, 5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JMP,  250,  0,     250, 0, 0, 0, 0));
    for (int i = 251; i <= 255; i++)
      vecs.push_back(mk(1, 1, OP_SEQ, 0, 0, 8'(i), 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_SEQ,  0,    0,     0,   0, 0, 0, 1));
    vecs.push_back(mk(1, 1, OP_BRR,  0,    8'hFD, 253, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_JMP,  10,   0,     10,  0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 40,   0,     40,  1, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 80,   0,     80,  2, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 120,  0,     120, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 160,  0,     160, 4, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 200,  0,     161, 4, 1, 0, 0));
    vecs.push_back(mk(1, 0, OP_RET,  0,    0,     161, 4, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     121, 3, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     81,  2, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     41,  1, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     11,  0, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_JMP,  30,   0,     30,  0, 1, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     31,  0, 1, 1, 0));
    vecs.push_back(mk(1, 1, OP_SEQ,  0,    0,     32,  0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 3'd6,    0,    0,     33,  0, 1, 1, 0));
    vecs.push_back(mk(1, 1, OP_SEQ,  0,    0,     34,  0, 1, 1, 0));
    vecs.push_back(mk(0, 1, OP_CALL, 99,   0,     0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_CALL, 99,   0,     99,  1, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_RET,  0,    0,     1,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, OP_BRR,  0,    8'h05, 6,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3'd7,    0,    0,     7,   0, 0, 0, 0));

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; op = vecs[i].op;
      target = vecs[i].target; offset = vecs[i].offset;
      @(posedge clk); #1;
      checks++;
      if (pc !== vecs[i].exp_pc || sp !== vecs[i].exp_sp ||
          stack_empty !== vecs[i].exp_empty || stack_full !== vecs[i].exp_full ||
          ovf_err !== vecs[i].exp_ovf || unf_err !== vecs[i].exp_unf) begin
        errors++;
        $display("FAIL vec%0d: got pc=%0d sp=%0d e=%b f=%b ovf=%b unf=%b, expected pc=%0d sp=%0d e=%b f=%b ovf=%b unf=%b",
                 i, pc, sp, stack_empty, stack_full, ovf_err, unf_err,
                 vecs[i].exp_pc, vecs[i].exp_sp, vecs[i].exp_empty, vecs[i].exp_full,
                 vecs[i].exp_ovf, vecs[i].exp_unf);
      end
`ifdef PC_WRAP_FLAG_EN
      checks++;
      if (wrapped !== vecs[i].exp_wrap) begin
        errors++;
        $display("FAIL wrap%0d: got wrapped=%b, expected %b", i, wrapped, vecs[i].exp_wrap);
      end
`endif
    end

    // Alternate configuration: reset vector and step size
    step2(1'b0, OP_SEQ, 8'd0);
    check_dut2("alt_reset", 8'd16, 3'd0, 1'b0);
    step2(1'b1, OP_SEQ, 8'd0);
    step2(1'b1, OP_SEQ, 8'd0);
    step2(1'b1, OP_SEQ, 8'd0);
    check_dut2("alt_seq3", 8'd28, 3'd0, 1'b0);
    step2(1'b1, OP_RET, 8'd0);
    check_dut2("alt_ret_empty", 8'd32, 3'd0, 1'b1);
    step2(1'b1, OP_CALL, 8'd100);
    check_dut2("alt_call", 8'd100, 3'd1, 1'b1);
    step2(1'b1, OP_RET, 8'd0);
    check_dut2("alt_ret", 8'd36, 3'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the sequencer datapath.
- Adds the following on top of the plain increment/load counter:
  - configurable width, step and reset vector;
  - stall;
  - absolute jump and signed relative branch;
  - CALL/RET with an internal return-address stack.
- Drives the instruction-memory address; the decode stage supplies op, target and offset.

Parameters:
- PC_W, 8, PC width in bits (>=2).
- STEP, 1, sequential increment amount (1..2^PC_W-1).
- RESET_PC, 0, PC value after reset (PC_W bits).
- STACK_DEPTH, 4, return-address stack entries (power of 2, >=2).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active low.
- en  in  1  advance enable; 0 = stall (hold everything).
- op  in  3  pc_op_t: SEQ=0, JMP=1, BRR=2, CALL=3, RET=4; 5..7 treated as SEQ.
- target  in  PC_W  absolute destination for JMP/CALL.
- offset  in  PC_W  two's-complement displacement for BRR.
- pc  out  PC_W  current program counter (registered).
- sp  out  $clog2(STACK_DEPTH)+1  stack occupancy, 0..STACK_DEPTH.
- stack_empty  out  1  sp==0 (combinational from sp).
- stack_full  out  1  sp==STACK_DEPTH.
- ovf_err  out  1  sticky: CALL attempted while full.
- unf_err  out  1  sticky: RET attempted while empty.

Behaviour:
- Single clock domain; reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values:
  - pc=RESET_PC, sp=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0;
  - stack contents don't-care.
- Priority per edge: !rst_n > !en > op.
- Reset mid-operation discards any pending op and clears the error flags.
- en=0: pc, sp, stack and error flags hold; op/target/offset ignored.
- en=1, by op (all PC arithmetic modulo 2^PC_W, no saturation):
  - SEQ: pc <= pc+STEP. Wrap-around is silent; e.g. PC_W=8, pc=255, STEP=1 gives 0.
  - JMP: pc <= target.
  - BRR: pc <= pc + offset; offset is signed, so 8'hFE moves back 2.
  - CALL, not full: push pc+STEP at index sp; sp <= sp+1; pc <= target.
  - CALL, full: no push, sp unchanged, pc <= pc+STEP, ovf_err <= 1.
  - RET, not empty: pc <= stack[sp-1]; sp <= sp-1.
  - RET, empty: pc <= pc+STEP, unf_err <= 1.
- Latency: every update is visible on pc one cycle after the sampling edge; no combinational path from inputs to pc.
- Error flags stay set until reset.
- The stack is LIFO with no wrap: the oldest entry is never overwritten.

Optional Feature:
- Macro PC_WRAP_FLAG_EN.
- Defined: extra output port `wrapped` (1 bit, registered, reset 0).
  - Pulses high for one cycle after any SEQ/CALL-fallback/RET-fallback increment whose true sum exceeds 2^PC_W-1.
  - Not asserted for JMP, BRR or a successful RET.
- Undefined: port absent; wrap-around remains silent; all other behaviour identical.

Decomposition:
- Package pc_pkg:
  - pc_op_t enum (3-bit, values above);
  - localparams for op encoding widths.
- Sub-module ra_stack (params W=PC_W, DEPTH=STACK_DEPTH):
  - inputs push, pop, din;
  - outputs dout (top entry), count, full, empty;
  - ignores push when full and pop when empty.
- pc_stack_unit owns the PC register, next-PC mux and error flags.

Test Plan:
All cases use PC_W=8, STEP=1, RESET_PC=0, STACK_DEPTH=4 unless stated.
- Reset/stall: hold rst_n=0 for 2 edges, then SEQ for 5 edges -> pc=5. Then en=0 for 3 edges -> pc stays 5, sp=0.
- Jump/branch/wrap:
  - JMP target=250, then 6 SEQ -> pc=0;
  - BRR offset=8'hFD from pc=0 -> pc=253;
  - if PC_WRAP_FLAG_EN, `wrapped` pulses once on the 255->0 edge.
- Nested calls: from pc=10 CALL 40, then CALL 80, CALL 120, CALL 160 -> sp=4, stack_full=1. Four RETs -> pc=121, 81, 41, 11; stack_empty=1.
- Overflow: with full stack, CALL target=200 at pc=160 -> pc=161, sp=4, ovf_err=1. Then a RET -> pc=121.
- Underflow: empty stack, RET at pc=30 -> pc=31, unf_err=1. unf_err persists through 3 SEQ; cleared only by rst_n=0.
- Reset mid-call: assert rst_n=0 on the same edge as CALL 99 -> pc=0, sp=0, no push. Alternate config STEP=4, RESET_PC=16: 3 SEQ -> pc=28.
